// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits
// with odd parity and stop, device ACK check, per-edge timeout supervision.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYC = 2500,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_WAITIDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic          fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == INH_LAST) begin
          ps2_dat_oe = 1'b1;
          cnt_d      = '0;
          state_d    = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ, S_BITS, S_ACK, S_WAITIDLE: begin
        // Timeout is checked first so an edge landing in the same cycle is dropped.
        if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ps2_dat_oe = (state_q == S_REQ) | ((state_q == S_BITS) & ~frame_q[0]);
          cnt_d      = fall ? '0 : cnt_q + 1'b1;
          case (state_q)
            S_REQ: if (fall) begin
              bit_d   = '0;
              state_d = S_BITS;
            end
            // frame_q[0] is the bit on the wire; the 9th shift exposes the stop bit.
            S_BITS: if (fall) begin
              frame_d = {1'b1, frame_q[9:1]};
              bit_d   = bit_q + 1'b1;
              if (bit_q == 4'd8) state_d = S_ACK;
            end
            S_ACK: if (fall) begin
              if (!dat_sync_q[1]) begin
                state_d = S_WAITIDLE;
              end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
              end
            end
            default: if (clk_sync_q[1] && dat_sync_q[1]) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames out of the host,
// and each frame is compared with the byte/parity/stop layout it should carry.
module tb_ps2_tx;

  localparam int unsigned INH = 2500;
  localparam int unsigned TO  = 600;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, done_busy = 0;
  int unsigned inh_run = 0, inh_len = 0, inh_dat_run = 0, inh_dat = 0;
  logic        clk_oe_prev = 1'b0, inh_run_last = 1'b0, inh_last_dat = 1'b0;

  always @(negedge clock) begin
    cyc         <= cyc + 1;
    done_cnt    <= done_cnt + 32'(done);
    err_cnt     <= err_cnt + 32'(error);
    both_cnt    <= both_cnt + 32'(done & error);
    done_busy   <= done_busy + 32'(done & busy);
    clk_oe_prev <= ps2_clk_oe;
    if (ps2_clk_oe) begin
      inh_run      <= inh_run + 1;
      inh_dat_run  <= inh_dat_run + 32'(ps2_dat_oe);
      inh_run_last <= ps2_dat_oe;
    end else if (clk_oe_prev) begin
      inh_len      <= inh_run;
      inh_dat      <= inh_dat_run;
      inh_last_dat <= inh_run_last;
      inh_run      <= 0;
      inh_dat_run  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Device side: waits for request-to-send, then generates n_edges falling
  // edges, sampling the data line late in each low phase.
  task automatic device_frame(input int unsigned n_edges, input bit ack,
                              input int unsigned inject_edge,
                              output logic [10:0] bits, output bit ok,
                              output int unsigned t_fall);
    int unsigned hp, guard;
    bits = '0;
    ok = 1'b0;
    t_fall = 0;
    guard = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && guard < INH + 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard < INH + 100) begin
      ok = 1'b1;
      hp = $urandom_range(25, 8);
      repeat (hp) @(negedge clock);
      bits[0] = ps2_dat_in;
      for (int unsigned e = 1; e <= n_edges; e++) begin
        if (e == 11) dev_dat = ~ack;
        dev_clk = 1'b0;
        t_fall = cyc;
        if (e == inject_edge) begin
          @(negedge clock);
          tx_data  = 8'h55;
          tx_start = 1'b1;
          @(negedge clock);
          tx_start = 1'b0;
          repeat (hp - 2) @(negedge clock);
        end else begin
          repeat (hp) @(negedge clock);
        end
        if (e <= 10) bits[e] = ps2_dat_in;
        dev_clk = 1'b1;
        repeat (hp) @(negedge clock);
        if (e == 11) dev_dat = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit ack, input int unsigned n_edges,
                      input int unsigned inject_edge);
    logic [10:0] bits, exp_frame;
    bit          ok, full;
    int unsigned t_fall, guard, d0, e0;
    full = (n_edges == 11);
    d0 = done_cnt;
    e0 = err_cnt;
    check("idle_busy", 32'(busy), 0);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_rise", 32'(busy), 1);
    device_frame(n_edges, ack, inject_edge, bits, ok, t_fall);
    check("req_phase", 32'(ok), 1);
    guard = 0;
    if (!full) begin
      while (error !== 1'b1 && guard < TO + 50) begin
        @(negedge clock);
        guard++;
      end
      // TIMEOUT_CYC-1 counter span plus synchronizer and edge-detect delay.
      check("timeout_lat", cyc - t_fall, TO + 3);
      check("timeout_busy", 32'(busy), 0);
    end else begin
      while (busy !== 1'b0 && guard < TO) begin
        @(negedge clock);
        guard++;
      end
      check("end_bound", 32'(guard < TO), 1);
      if (ack) check("busy_with_done", 32'(done), 1);
      exp_frame = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
      check("frame", 32'(bits), 32'(exp_frame));
      check("inhibit_len", inh_len, INH);
      check("inhibit_dat_cycles", inh_dat, 1);
      check("inhibit_dat_last", 32'(inh_last_dat), 1);
    end
    @(negedge clock);
    @(negedge clock);
    check("done_count", done_cnt - d0, (ack && full) ? 1 : 0);
    check("error_count", err_cnt - e0, (ack && full) ? 0 : 1);
    check("lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
  endtask

  initial begin
    int unsigned d0, e0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    send(8'hED, 1'b1, 11, 0);
    send(8'h01, 1'b0, 11, 0);
    send(8'hF4, 1'b1, 11, 3);
    send(8'h3C, 1'b1, 4, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    repeat (100) @(negedge clock);
    check("inhibit_active", 32'(ps2_clk_oe), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("async_rst_dat_oe", 32'(ps2_dat_oe), 0);
    check("async_rst_busy", 32'(busy), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_error", err_cnt - e0, 0);
    send(8'hFF, 1'b1, 11, 0);

    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), ($urandom_range(3, 0) != 0), 11, 0);
    end

    check("done_error_overlap", both_cnt, 0);
    check("done_while_busy", done_busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got stuck, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
